// File: rtl/rggen_rtl_pkg.sv
// Shared types for the rggen register-block host adapters: bus status, access
// direction and the AXI4-Lite adapter state encoding.
package rggen_rtl_pkg;

  // Status values share the AXI RESP encoding so they pass through unchanged.
  typedef enum logic [1:0] {
    RGGEN_OKAY          = 2'b00,
    RGGEN_EXOKAY        = 2'b01,
    RGGEN_SLAVE_ERROR   = 2'b10,
    RGGEN_ADDRESS_ERROR = 2'b11
  } rggen_status;

  typedef enum logic {
    RGGEN_READ  = 1'b0,
    RGGEN_WRITE = 1'b1
  } rggen_direction;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WRESP,
    RRESP
  } rggen_axi4lite_state;

endpackage

// File: rtl/rggen_axi4lite_adapter_if.sv
// AXI4-Lite host port of the register block; the adapter sits on the slave side.
interface rggen_axi4lite_adapter_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
);
  logic                      awvalid;
  logic                      awready;
  logic [ADDRESS_WIDTH-1:0]  awaddr;
  logic [2:0]                awprot;
  logic                      wvalid;
  logic                      wready;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      bvalid;
  logic                      bready;
  logic [1:0]                bresp;
  logic                      arvalid;
  logic                      arready;
  logic [ADDRESS_WIDTH-1:0]  araddr;
  logic [2:0]                arprot;
  logic                      rvalid;
  logic                      rready;
  logic [DATA_WIDTH-1:0]     rdata;
  logic [1:0]                rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/rggen_bus_if.sv
// Internal register bus between the host adapter and the bus splitter.
interface rggen_bus_if
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
);
  logic                      request;
  logic [ADDRESS_WIDTH-1:0]  address;
  rggen_direction            direction;
  logic [DATA_WIDTH-1:0]     write_data;
  logic [DATA_WIDTH/8-1:0]   write_strobe;
  logic                      done;
  logic                      write_done;
  logic                      read_done;
  logic [DATA_WIDTH-1:0]     read_data;
  rggen_status               status;

  modport master (
    output request, address, direction, write_data, write_strobe,
    input  done, write_done, read_done, read_data, status
  );

  modport slave (
    input  request, address, direction, write_data, write_strobe,
    output done, write_done, read_done, read_data, status
  );
endinterface

// File: rtl/rggen_axi4lite_hold_slot.sv
// One-entry valid/ready holding register; the payload stays put until the
// owner releases it, and ready is a flop so it is low throughout reset.
module rggen_axi4lite_hold_slot #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  output logic             ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic             release_slot,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  // Release and load are exclusive: release only happens while full, load only while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full  <= 1'b0;
      ready <= 1'b0;
      data  <= '0;
    end else if (release_slot) begin
      full  <= 1'b0;
      ready <= 1'b1;
    end else if (valid && ready) begin
      full  <= 1'b1;
      ready <= 1'b0;
      data  <= data_in;
    end else begin
      ready <= !full;
    end
  end

endmodule

// File: rtl/rggen_axi4lite_adapter.sv
// AXI4-Lite to rggen_bus_if bridge: buffers AW/W/AR, serves one access at a time
// with read/write alternation, and returns the B/R response.
module rggen_axi4lite_adapter
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
) (
  input logic                     clk,
  input logic                     rst_n,
  rggen_axi4lite_adapter_if.slave axi_if,
  rggen_bus_if.master             bus_if
);

  localparam int STROBE_WIDTH = DATA_WIDTH / 8;

  rggen_axi4lite_state                   state;
  logic                                  read_priority;
  logic                                  aw_full;
  logic                                  w_full;
  logic                                  ar_full;
  logic [ADDRESS_WIDTH-1:0]              aw_addr;
  logic [ADDRESS_WIDTH-1:0]              ar_addr;
  logic [DATA_WIDTH+STROBE_WIDTH-1:0]    w_payload;
  logic                                  write_pending;
  logic                                  read_pending;
  logic                                  write_release;
  logic                                  read_release;
  logic                                  unused_inputs;

  assign write_pending = aw_full && w_full;
  assign read_pending  = ar_full;
  assign write_release = (state == ACCESS) && bus_if.done && (bus_if.direction == RGGEN_WRITE);
  assign read_release  = (state == ACCESS) && bus_if.done && (bus_if.direction == RGGEN_READ);
  assign unused_inputs = ^{axi_if.awprot, axi_if.arprot, bus_if.write_done, bus_if.read_done};

  rggen_axi4lite_hold_slot #(.WIDTH(ADDRESS_WIDTH)) u_aw_slot (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid        (axi_if.awvalid),
    .ready        (axi_if.awready),
    .data_in      (axi_if.awaddr),
    .release_slot (write_release),
    .full         (aw_full),
    .data         (aw_addr)
  );

  rggen_axi4lite_hold_slot #(.WIDTH(DATA_WIDTH + STROBE_WIDTH)) u_w_slot (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid        (axi_if.wvalid),
    .ready        (axi_if.wready),
    .data_in      ({axi_if.wdata, axi_if.wstrb}),
    .release_slot (write_release),
    .full         (w_full),
    .data         (w_payload)
  );

  rggen_axi4lite_hold_slot #(.WIDTH(ADDRESS_WIDTH)) u_ar_slot (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid        (axi_if.arvalid),
    .ready        (axi_if.arready),
    .data_in      (axi_if.araddr),
    .release_slot (read_release),
    .full         (ar_full),
    .data         (ar_addr)
  );

  // Slots are frozen until done, so the request payload is stable for the whole access.
  assign bus_if.address      = (bus_if.direction == RGGEN_WRITE) ? aw_addr : ar_addr;
  assign bus_if.write_data   = w_payload[DATA_WIDTH+STROBE_WIDTH-1:STROBE_WIDTH];
  assign bus_if.write_strobe = w_payload[STROBE_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      read_priority    <= 1'b1;
      bus_if.request   <= 1'b0;
      bus_if.direction <= RGGEN_READ;
      axi_if.bvalid    <= 1'b0;
      axi_if.bresp     <= 2'b00;
      axi_if.rvalid    <= 1'b0;
      axi_if.rdata     <= '0;
      axi_if.rresp     <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (read_pending && (!write_pending || read_priority)) begin
            state            <= ACCESS;
            bus_if.request   <= 1'b1;
            bus_if.direction <= RGGEN_READ;
          end else if (write_pending) begin
            state            <= ACCESS;
            bus_if.request   <= 1'b1;
            bus_if.direction <= RGGEN_WRITE;
          end
          if (read_pending && write_pending) begin
            read_priority <= !read_priority;
          end
        end
        ACCESS: begin
          if (bus_if.done) begin
            bus_if.request <= 1'b0;
            if (bus_if.direction == RGGEN_WRITE) begin
              state         <= WRESP;
              axi_if.bvalid <= 1'b1;
              axi_if.bresp  <= bus_if.status;
            end else begin
              state         <= RRESP;
              axi_if.rvalid <= 1'b1;
              axi_if.rdata  <= bus_if.read_data;
              axi_if.rresp  <= bus_if.status;
            end
          end
        end
        WRESP: begin
          if (axi_if.bready) begin
            state         <= IDLE;
            axi_if.bvalid <= 1'b0;
            axi_if.bresp  <= 2'b00;
          end
        end
        RRESP: begin
          if (axi_if.rready) begin
            state         <= IDLE;
            axi_if.rvalid <= 1'b0;
            axi_if.rdata  <= '0;
            axi_if.rresp  <= 2'b00;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
